// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared state type and sizing helpers for the serial adder
package serial_adder_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  function automatic int calc_n(int width, int digit);
    return width / digit;
  endfunction
  function automatic int calc_cw(int width, int digit);
    int n = calc_n(width, digit);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/serial_adder_if.sv
// serial_adder_if: start/done handshake, operands and result of the serial adder
interface serial_adder_if #(parameter int WIDTH = 8);
  logic             start;
  logic             cin;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  modport master(output start, a, b, cin, input ready, busy, done, sum, cout);
  modport slave(input start, a, b, cin, output ready, busy, done, sum, cout);
endinterface

// File: rtl/adder_digit.sv
// adder_digit: combinational DIGIT-bit ripple adder built from full-adder cells
module adder_digit #(parameter int DIGIT = 1) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             ci,
  output logic [DIGIT-1:0] s,
  output logic             co
);
  logic c;
  always_comb begin
    s = '0;
    c = ci;
    for (int i = 0; i < DIGIT; i++) begin
      s[i] = x[i] ^ y[i] ^ c;
      c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
    end
    co = c;
  end
endmodule

// File: rtl/serial_adder.sv
// serial_adder: multi-cycle a+b+cin, DIGIT bits per clock, LSB first
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input logic          clk,
  input logic          rst,
  serial_adder_if.slave bus
);
  localparam int N  = calc_n(WIDTH, DIGIT);
  localparam int CW = calc_cw(WIDTH, DIGIT);
  if (WIDTH < 1 || DIGIT < 1 || WIDTH % DIGIT != 0) begin : g_bad_param
    $error("serial_adder: DIGIT must divide WIDTH");
  end
  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, ps_q, ps_d, sum_q, sum_d;
  logic             c_q, c_d, cout_q, cout_d, done_q, done_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [DIGIT-1:0] s;
  logic             co, go, run, last;
  adder_digit #(.DIGIT(DIGIT)) u_digit (
    .x (a_q[DIGIT-1:0]),
    .y (b_q[DIGIT-1:0]),
    .ci(c_q),
    .s (s),
    .co(co)
  );
  always_comb begin
    go      = state_q == IDLE && bus.start;
    run     = state_q == RUN;
    last    = cnt_q == CW'(N - 1);
    state_d = go ? RUN : run ? (last ? DONE : RUN) : IDLE;
    a_d     = go ? bus.a : run ? a_q >> DIGIT : a_q;
    b_d     = go ? bus.b : run ? b_q >> DIGIT : b_q;
    c_d     = go ? bus.cin : run ? co : c_q;
    cnt_d   = go ? '0 : run ? cnt_q + CW'(1) : cnt_q;
    // each new digit enters at the top so the LSB digit lands at bit 0 after N shifts
    ps_d    = go ? '0 : run ? WIDTH'({s, ps_q} >> DIGIT) : ps_q;
    sum_d   = run && last ? ps_d : sum_q;
    cout_d  = run && last ? co : cout_q;
    done_d  = run && last;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      ps_q    <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      ps_q    <= ps_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      done_q  <= done_d;
    end
  end
  assign bus.ready = state_q == IDLE;
  assign bus.busy  = state_q != IDLE;
  assign bus.done  = done_q;
  assign bus.sum   = sum_q;
  assign bus.cout  = cout_q;
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: checks four width/digit configurations against a+b+cin arithmetic
module tb_serial_adder;
  logic clk, rst;
  int tests = 0, fails = 0;
  serial_adder_if #(.WIDTH(8)) i81 ();
  serial_adder_if #(.WIDTH(8)) i84 ();
  serial_adder_if #(.WIDTH(4)) i41 ();
  serial_adder_if #(.WIDTH(4)) i42 ();
  serial_adder #(.WIDTH(8), .DIGIT(1)) d81 (.clk(clk), .rst(rst), .bus(i81));
  serial_adder #(.WIDTH(8), .DIGIT(4)) d84 (.clk(clk), .rst(rst), .bus(i84));
  serial_adder #(.WIDTH(4), .DIGIT(1)) d41 (.clk(clk), .rst(rst), .bus(i41));
  serial_adder #(.WIDTH(4), .DIGIT(2)) d42 (.clk(clk), .rst(rst), .bus(i42));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  function automatic int wof(int cfg);
    return cfg < 2 ? 8 : 4;
  endfunction
  function automatic int dof(int cfg);
    return cfg == 1 ? 4 : cfg == 3 ? 2 : 1;
  endfunction
  task automatic drive(input int cfg, input logic st, input logic [7:0] a, b, input logic ci);
    case (cfg)
      0: begin i81.start = st; i81.a = a; i81.b = b; i81.cin = ci; end
      1: begin i84.start = st; i84.a = a; i84.b = b; i84.cin = ci; end
      2: begin i41.start = st; i41.a = a[3:0]; i41.b = b[3:0]; i41.cin = ci; end
      default: begin i42.start = st; i42.a = a[3:0]; i42.b = b[3:0]; i42.cin = ci; end
    endcase
  endtask
  function automatic int get_sum(int cfg);
    return cfg == 0 ? int'(i81.sum) : cfg == 1 ? int'(i84.sum) : cfg == 2 ? int'(i41.sum) : int'(i42.sum);
  endfunction
  function automatic int get_cout(int cfg);
    return cfg == 0 ? int'(i81.cout) : cfg == 1 ? int'(i84.cout) : cfg == 2 ? int'(i41.cout) : int'(i42.cout);
  endfunction
  function automatic int get_done(int cfg);
    return cfg == 0 ? int'(i81.done) : cfg == 1 ? int'(i84.done) : cfg == 2 ? int'(i41.done) : int'(i42.done);
  endfunction
  function automatic int get_ready(int cfg);
    return cfg == 0 ? int'(i81.ready) : cfg == 1 ? int'(i84.ready) : cfg == 2 ? int'(i41.ready) : int'(i42.ready);
  endfunction
  function automatic int get_busy(int cfg);
    return cfg == 0 ? int'(i81.busy) : cfg == 1 ? int'(i84.busy) : cfg == 2 ? int'(i41.busy) : int'(i42.busy);
  endfunction
  task automatic check(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic check_idle(input int cfg, input string tag);
    check({tag, " ready"}, get_ready(cfg), 1);
    check({tag, " busy"}, get_busy(cfg), 0);
    check({tag, " done"}, get_done(cfg), 0);
    check({tag, " sum"}, get_sum(cfg), 0);
    check({tag, " cout"}, get_cout(cfg), 0);
  endtask
  task automatic run(input int cfg, input logic [7:0] a, b, input logic ci, input string tag);
    int w, n, cyc, tot, s0, c0;
    w   = wof(cfg);
    n   = w / dof(cfg);
    tot = (int'(a) % (1 << w)) + (int'(b) % (1 << w)) + int'(ci);
    @(negedge clk);
    check({tag, " ready"}, get_ready(cfg), 1);
    s0 = get_sum(cfg);
    c0 = get_cout(cfg);
    drive(cfg, 1'b1, a, b, ci);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        drive(cfg, 1'b0, 8'($urandom), 8'($urandom), 1'($urandom));
        check({tag, " busy"}, get_busy(cfg), 1);
      end
      if (get_done(cfg) == 0)
        check({tag, " hold"}, get_cout(cfg) * 256 + get_sum(cfg), c0 * 256 + s0);
    end while (get_done(cfg) == 0 && cyc < n + 4);
    check({tag, " latency"}, cyc, n + 1);
    check({tag, " sum"}, get_sum(cfg), tot % (1 << w));
    check({tag, " cout"}, get_cout(cfg), (tot >> w) & 1);
    @(negedge clk);
    check({tag, " done_once"}, get_done(cfg), 0);
    check({tag, " ready_after"}, get_ready(cfg), 1);
  endtask
  initial begin
    int first, pulses;
    for (int c = 0; c < 4; c++) drive(c, 1'b0, 8'h00, 8'h00, 1'b0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) check_idle(c, $sformatf("reset%0d", c));
    run(0, 8'h5A, 8'h3C, 1'b0, "w8d1_5a3c");
    run(0, 8'hFF, 8'h00, 1'b1, "w8d1_ff00c");
    repeat (3) @(negedge clk);
    check("w8d1_stable sum", get_sum(0), 8'h00);
    check("w8d1_stable cout", get_cout(0), 1);
    run(0, 8'hFF, 8'hFF, 1'b1, "w8d1_ffffc");
    run(1, 8'h7F, 8'h01, 1'b0, "w8d4_7f01");
    for (int k = 0; k < 8; k++) begin
      run(0, 8'($urandom), 8'($urandom), 1'($urandom), "w8d1_rand");
      run(1, 8'($urandom), 8'($urandom), 1'($urandom), "w8d4_rand");
    end
    @(negedge clk);
    drive(0, 1'b1, 8'h0F, 8'h01, 1'b0);
    first  = 0;
    pulses = 0;
    for (int cyc = 1; cyc <= 14; cyc++) begin
      @(negedge clk);
      if (cyc == 1) drive(0, 1'b0, 8'h0F, 8'h01, 1'b0);
      if (cyc == 2) drive(0, 1'b1, 8'hAA, 8'h55, 1'b1);
      if (cyc == 3) drive(0, 1'b0, 8'h33, 8'hC4, 1'b1);
      if (get_done(0) == 1) begin
        pulses++;
        if (first == 0) first = cyc;
      end
    end
    check("ignore_start pulses", pulses, 1);
    check("ignore_start latency", first, 9);
    check("ignore_start sum", get_sum(0), 8'h10);
    check("ignore_start cout", get_cout(0), 0);
    drive(0, 1'b1, 8'hC3, 8'h7E, 1'b1);
    @(negedge clk);
    drive(0, 1'b0, 8'h00, 8'h00, 1'b0);
    repeat (3) @(negedge clk);
    check("midrun busy", get_busy(0), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_idle(0, "midrun_rst");
    pulses = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      @(negedge clk);
      if (get_done(0) == 1) pulses++;
    end
    check("midrun_rst no_done", pulses, 0);
    check("midrun_rst sum_held", get_sum(0), 0);
    run(0, 8'hC3, 8'h7E, 1'b1, "after_rst");
    for (int c = 2; c < 4; c++)
      for (int x = 0; x < 16; x++)
        for (int y = 0; y < 16; y++)
          for (int ci = 0; ci < 2; ci++)
            run(c, 8'(x), 8'(y), 1'(ci), $sformatf("exh%0d_%0h_%0h_%0d", c, x, y, ci));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
